// File: rtl/multisim_apb_pkg.sv
// Shared types for the multisim APB server-channel arbiter.
// Defines the arbiter state encoding and default APB request/response
// payload structs. The arbiter treats the payloads as opaque and only
// steers them between lanes.
package multisim_apb_pkg;

  localparam int unsigned MULTISIM_APB_ADDR_W = 32;
  localparam int unsigned MULTISIM_APB_DATA_W = 32;
  localparam int unsigned MULTISIM_APB_STRB_W = MULTISIM_APB_DATA_W / 8;

  // Downstream transfer phase owned by the arbiter.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } multisim_apb_arb_state_t;

  // Default request payload: everything a manager presents alongside PSEL.
  typedef struct packed {
    logic [MULTISIM_APB_ADDR_W-1:0] addr;
    logic                           write;
    logic [MULTISIM_APB_DATA_W-1:0] wdata;
    logic [MULTISIM_APB_STRB_W-1:0] strb;
    logic [2:0]                     prot;
  } multisim_apb_req_t;

  // Default response payload returned with PREADY.
  typedef struct packed {
    logic [MULTISIM_APB_DATA_W-1:0] rdata;
    logic                           slverr;
  } multisim_apb_resp_t;

endpackage : multisim_apb_pkg

// File: rtl/multisim_rr_arbiter.sv
// Combinational round-robin picker.
// Searches the request vector cyclically starting one past the last
// winner (ptr), so the last winner has the lowest priority next time.
module multisim_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_vld
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] cand;

  // Pick the first set request at ptr+1, ptr+2, ... wrapping modulo N.
  always_comb begin
    // NOTE: every variable written here gets a default before the loop, so
    // no path leaves it unassigned and no latch is inferred.
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int off = 1; off <= N; off++) begin
      cand = IW'((int'(ptr) + off) % N);
      if (!gnt_vld && req[cand]) begin
        gnt_idx = cand;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule : multisim_rr_arbiter

// File: rtl/multisim_apb_arbiter.sv
// Shares one APB server channel (feeding the multisim push/pull bridge)
// between NUM_MGR upstream APB managers.
//  - Round-robin grant, one transfer in flight, grant locked until the
//    downstream PREADY.
//  - Upstream PREADY/response are returned in the same cycle the bridge
//    answers (no added latency on the response path).
//  - A per-transfer watchdog raises a sticky flag when the simulator-side
//    server keeps the ACCESS phase waiting too long; the transfer itself is
//    never aborted, because the server may still answer eventually.
module multisim_apb_arbiter
  import multisim_apb_pkg::*;
#(
  parameter int  NUM_MGR        = 4,
  parameter int  TIMEOUT_CYCLES = 1024,
  parameter type apb_req_t      = multisim_apb_req_t,
  parameter type apb_resp_t     = multisim_apb_resp_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  apb_req_t                   i_apb_m_req [NUM_MGR],
  input  logic [NUM_MGR-1:0]         i_apb_m_psel,
  input  logic [NUM_MGR-1:0]         i_apb_m_penable,
  output apb_resp_t                  o_apb_m_resp [NUM_MGR],
  output logic [NUM_MGR-1:0]         o_apb_m_pready,
  output apb_req_t                   o_apb_s_req,
  output logic                       o_apb_s_psel,
  output logic                       o_apb_s_penable,
  input  apb_resp_t                  i_apb_s_resp,
  input  logic                       i_apb_s_pready,
  output logic [$clog2(NUM_MGR)-1:0] o_grant,
  output logic                       o_busy,
  output logic                       o_timeout
);

  localparam int IW = $clog2(NUM_MGR);

  // Watchdog counter is wide enough to hold TIMEOUT_CYCLES; a disabled
  // watchdog still gets a 1-bit counter so the logic stays uniform.
  localparam int            WDW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT_CYCLES);
  localparam bit            WD_EN    = (TIMEOUT_CYCLES > 0);

  multisim_apb_arb_state_t state_q;
  multisim_apb_arb_state_t state_d;

  logic [IW-1:0]  grant_q;   // lane owning the channel (held after the transfer)
  logic [IW-1:0]  ptr_q;     // last lane that completed a transfer
  logic [IW-1:0]  arb_idx;
  logic           arb_vld;
  logic [WDW-1:0] wdog_q;
  logic           timeout_q;

  logic           start_xfer;
  logic           end_xfer;

  // Arbitration looks at PSEL only: a manager is requesting from its own
  // SETUP phase onward, whatever its PENABLE level.
  multisim_rr_arbiter #(
    .N (NUM_MGR)
  ) u_rr_arbiter (
    .req     (i_apb_m_psel),
    .ptr     (ptr_q),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  assign start_xfer = (state_q == IDLE) && arb_vld;
  assign end_xfer   = (state_q == ACCESS) && i_apb_s_pready;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and the result never depends on block order.
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> SETUP -> ACCESS (held until PREADY) -> IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arb_vld)        state_d = SETUP;
      SETUP:                       state_d = ACCESS;
      ACCESS:  if (i_apb_s_pready) state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // Grant is captured when a transfer starts; the round-robin pointer moves
  // to that lane only once its transfer has completed downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= '0;
      ptr_q   <= IW'(NUM_MGR - 1);
    end else begin
      if (start_xfer) grant_q <= arb_idx;
      if (end_xfer)   ptr_q   <= grant_q;
    end
  end

  // Watchdog: restart on every new transfer, count ACCESS cycles without
  // PREADY, saturate at the limit and latch the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else if (start_xfer) begin
      wdog_q <= '0;
    end else if (WD_EN && (state_q == ACCESS) && !i_apb_s_pready && (wdog_q != WD_LIMIT)) begin
      wdog_q <= wdog_q + WDW'(1);
      if (wdog_q + WDW'(1) == WD_LIMIT) timeout_q <= 1'b1;
    end
  end

  // Output decode: downstream phase signals, request mux and response demux.
  always_comb begin
    o_apb_s_psel    = (state_q != IDLE);
    o_apb_s_penable = (state_q == ACCESS);
    o_apb_s_req     = '0;
    if (state_q != IDLE) o_apb_s_req = i_apb_m_req[grant_q];
    for (int m = 0; m < NUM_MGR; m++) begin
      o_apb_m_pready[m] = 1'b0;
      o_apb_m_resp[m]   = '0;
      if ((state_q == ACCESS) && (grant_q == IW'(m))) begin
        o_apb_m_pready[m] = i_apb_s_pready;
        o_apb_m_resp[m]   = i_apb_s_resp;
      end
    end
  end

  assign o_grant   = grant_q;
  assign o_busy    = (state_q != IDLE);
  assign o_timeout = timeout_q;

  // Protocol checks: the granted manager must hold PSEL for the whole
  // transfer and be in its own ACCESS phase while the bridge is; the bridge
  // never answers during SETUP.
  a_grant_psel_held: assert property (@(posedge clk) disable iff (rst)
    (state_q != IDLE) |-> i_apb_m_psel[grant_q]);

  a_grant_penable_access: assert property (@(posedge clk) disable iff (rst)
    (state_q == ACCESS) |-> i_apb_m_penable[grant_q]);

  a_no_pready_in_setup: assert property (@(posedge clk) disable iff (rst)
    (state_q == SETUP) |-> !i_apb_s_pready);

endmodule : multisim_apb_arbiter
